mdr_mem_ctrl: RTL and testbench

Memory-access sequencer for the CPU datapath's MAR/MDR pair. It accepts single read or write requests from the control unit. It generates the MARin, MDRin and MDR mux-select (`read`) strobes in the correct order, drives the memory read/write strobes, and waits for memory acknowledge with a bounded wait-state counter. It sits between the control unit and the MAR/MDR registers plus the memory port, replacing hand-sequenced control steps for every load/store.

---
 rtl/mdr_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_mdr_mem_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_ctrl.sv
// Memory-access sequencer for the MAR/MDR pair: orders the MARin/MDRin/read
// strobes, drives the memory read/write strobes and bounds the wait for mem_ready.
module mdr_mem_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic rd_req,
    input  logic wr_req,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        LOAD_MDR,
        RD_WAIT,
        RD_CAPTURE,
        WR_WAIT,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          marin_q, mdrin_q, read_q, mem_rd_q, mem_wr_q, busy_q, done_q;
    logic          marin_d, mdrin_d, read_d, mem_rd_d, mem_wr_d, busy_d, done_d;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                // A simultaneous read and write request resolves to the read.
                if (rd_req || wr_req) begin
                    is_wr_d   = !rd_req;
                    timeout_d = 1'b0;
                    state_d   = LOAD_MAR;
                end
            end
            LOAD_MAR: begin
                if (is_wr_q) begin
                    state_d = LOAD_MDR;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            LOAD_MDR: begin
                state_d = WR_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    state_d = (state_q == RD_WAIT) ? RD_CAPTURE : DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_CAPTURE: state_d = DONE;
            DONE:       state_d = IDLE;
            ERR: begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end
            default:    state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        marin_d  = (state_d == LOAD_MAR);
        mdrin_d  = (state_d == LOAD_MDR) || (state_d == RD_CAPTURE);
        read_d   = (state_d == RD_WAIT) || (state_d == RD_CAPTURE);
        mem_rd_d = (state_d == RD_WAIT) || (state_d == RD_CAPTURE);
        mem_wr_d = (state_d == WR_WAIT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            marin_q   <= 1'b0;
            mdrin_q   <= 1'b0;
            read_q    <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            marin_q   <= marin_d;
            mdrin_q   <= mdrin_d;
            read_q    <= read_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign MARin   = marin_q;
    assign MDRin   = mdrin_q;
    assign read    = read_q;
    assign mem_rd  = mem_rd_q;
    assign mem_wr  = mem_wr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed-vector bench for mdr_mem_ctrl (WAIT_MAX=4) with a small MDR model
// fed by a memory that presents data while mem_rd is high.
module tb_mdr_mem_ctrl;

    logic clk;
    logic clr;
    logic rd_req;
    logic wr_req;
    logic mem_ready;
    logic MARin, MDRin, read, mem_rd, mem_wr, busy, done, timeout;

    logic [31:0] mdatain;
    logic [31:0] mdr;
    logic [7:0]  outs;

    int vectors;
    int miscompares;

    localparam logic [31:0] BUS_VAL = 32'h1234_5678;

    // Output vector packing: MARin MDRin read mem_rd mem_wr busy done timeout
    localparam logic [7:0] O_IDLE  = 8'h00;
    localparam logic [7:0] O_IDLET = 8'h01;
    localparam logic [7:0] O_MAR   = 8'h84;
    localparam logic [7:0] O_MDR   = 8'h44;
    localparam logic [7:0] O_RDW   = 8'h34;
    localparam logic [7:0] O_RDC   = 8'h74;
    localparam logic [7:0] O_WRW   = 8'h0C;
    localparam logic [7:0] O_DONE  = 8'h06;
    localparam logic [7:0] O_ERR   = 8'h04;

    mdr_mem_ctrl #(.WAIT_MAX(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .mem_ready (mem_ready),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .read      (read),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    assign outs    = {MARin, MDRin, read, mem_rd, mem_wr, busy, done, timeout};
    assign mdatain = mem_rd ? 32'hDEAD_BEEF : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MDRin) mdr <= read ? mdatain : BUS_VAL;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Check the current cycle's outputs, drive this cycle's inputs, advance one cycle.
    task automatic applyStimulus(input string tag, input logic [7:0] expected,
                                 input logic rd, input logic wr, input logic rdy);
        checkOutput(tag, {24'h0, outs}, {24'h0, expected});
        rd_req    = rd;
        wr_req    = wr;
        mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        mem_ready   = 1'b0;
        mdr         = 32'h0;
        clr         = 1'b0;
        #12;
        checkOutput("reset_outs", {24'h0, outs}, {24'h0, O_IDLE});
        checkOutput("reset_cnt", 32'(dut.cnt_q), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Read, zero wait states
        applyStimulus("rd0_c0", O_IDLE, 1, 0, 0);
        applyStimulus("rd0_c1", O_MAR,  0, 0, 0);
        applyStimulus("rd0_c2", O_RDW,  0, 0, 1);
        applyStimulus("rd0_c3", O_RDC,  0, 0, 0);
        checkOutput("rd0_mdr", mdr, 32'hDEAD_BEEF);
        applyStimulus("rd0_c4", O_DONE, 0, 0, 0);
        applyStimulus("rd0_c5", O_IDLE, 0, 0, 0);

        // Write, three wait states
        applyStimulus("wr3_c0", O_IDLE, 0, 1, 0);
        applyStimulus("wr3_c1", O_MAR,  0, 0, 0);
        applyStimulus("wr3_c2", O_MDR,  0, 0, 0);
        checkOutput("wr3_mdr", mdr, BUS_VAL);
        applyStimulus("wr3_c3", O_WRW,  0, 0, 0);
        applyStimulus("wr3_c4", O_WRW,  0, 0, 0);
        applyStimulus("wr3_c5", O_WRW,  0, 0, 0);
        applyStimulus("wr3_c6", O_WRW,  0, 0, 1);
        applyStimulus("wr3_c7", O_DONE, 0, 0, 0);
        applyStimulus("wr3_c8", O_IDLE, 0, 0, 0);

        // Read timeout, then a write clears the flag
        applyStimulus("to_c0",  O_IDLE,  1, 0, 0);
        applyStimulus("to_c1",  O_MAR,   0, 0, 0);
        applyStimulus("to_c2",  O_RDW,   0, 0, 0);
        applyStimulus("to_c3",  O_RDW,   0, 0, 0);
        applyStimulus("to_c4",  O_RDW,   0, 0, 0);
        applyStimulus("to_c5",  O_RDW,   0, 0, 0);
        applyStimulus("to_c6",  O_ERR,   0, 0, 0);
        applyStimulus("to_c7",  O_IDLET, 0, 0, 0);
        applyStimulus("to_c8",  O_IDLET, 0, 1, 0);
        applyStimulus("to_c9",  O_MAR,   0, 0, 0);
        applyStimulus("to_c10", O_MDR,   0, 0, 0);
        applyStimulus("to_c11", O_WRW,   0, 0, 1);
        applyStimulus("to_c12", O_DONE,  0, 0, 0);
        applyStimulus("to_c13", O_IDLE,  0, 0, 0);

        // Boundary: mem_ready on the last allowed wait cycle
        mdr = 32'h0;
        applyStimulus("bd_c0", O_IDLE, 1, 0, 0);
        applyStimulus("bd_c1", O_MAR,  0, 0, 0);
        applyStimulus("bd_c2", O_RDW,  0, 0, 0);
        applyStimulus("bd_c3", O_RDW,  0, 0, 0);
        applyStimulus("bd_c4", O_RDW,  0, 0, 0);
        applyStimulus("bd_c5", O_RDW,  0, 0, 1);
        applyStimulus("bd_c6", O_RDC,  0, 0, 0);
        checkOutput("bd_mdr", mdr, 32'hDEAD_BEEF);
        applyStimulus("bd_c7", O_DONE, 0, 0, 0);
        applyStimulus("bd_c8", O_IDLE, 0, 0, 0);

        // Arbitration: both requests, then a write pulse while busy
        applyStimulus("arb_c0", O_IDLE, 1, 1, 0);
        applyStimulus("arb_c1", O_MAR,  0, 1, 0);
        applyStimulus("arb_c2", O_RDW,  0, 0, 1);
        applyStimulus("arb_c3", O_RDC,  0, 0, 0);
        applyStimulus("arb_c4", O_DONE, 0, 0, 0);
        applyStimulus("arb_c5", O_IDLE, 0, 0, 0);
        applyStimulus("arb_c6", O_IDLE, 0, 0, 0);

        // Request held through DONE is re-accepted
        applyStimulus("hold_c0",  O_IDLE, 1, 0, 0);
        applyStimulus("hold_c1",  O_MAR,  1, 0, 0);
        applyStimulus("hold_c2",  O_RDW,  1, 0, 1);
        applyStimulus("hold_c3",  O_RDC,  1, 0, 0);
        applyStimulus("hold_c4",  O_DONE, 1, 0, 0);
        applyStimulus("hold_c5",  O_IDLE, 1, 0, 0);
        applyStimulus("hold_c6",  O_MAR,  0, 0, 0);
        applyStimulus("hold_c7",  O_RDW,  0, 0, 1);
        applyStimulus("hold_c8",  O_RDC,  0, 0, 0);
        applyStimulus("hold_c9",  O_DONE, 0, 0, 0);
        applyStimulus("hold_c10", O_IDLE, 0, 0, 0);

        // Reset asserted mid-write during WR_WAIT
        applyStimulus("rst_c0", O_IDLE, 0, 1, 0);
        applyStimulus("rst_c1", O_MAR,  0, 0, 0);
        applyStimulus("rst_c2", O_MDR,  0, 0, 0);
        applyStimulus("rst_c3", O_WRW,  0, 0, 0);
        checkOutput("rst_c4_outs", {24'h0, outs}, {24'h0, O_WRW});
        checkOutput("rst_c4_cnt", 32'(dut.cnt_q), 32'h1);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("rst_async_outs", {24'h0, outs}, {24'h0, O_IDLE});
        checkOutput("rst_async_cnt", 32'(dut.cnt_q), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_held_outs", {24'h0, outs}, {24'h0, O_IDLE});
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("rst_post0", O_IDLE, 0, 0, 1);
        applyStimulus("rst_post1", O_IDLE, 0, 0, 0);
        applyStimulus("rst_post2", O_IDLE, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
